// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcodes
// and the datapath mux encodings driven by the control unit.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_FETCH       = 5'd0,
        S_FETCH_WAIT  = 5'd1,
        S_DECODE      = 5'd2,
        S_MEM_ADDR    = 5'd3,
        S_MEM_RD      = 5'd4,
        S_MEM_RD_WAIT = 5'd5,
        S_MEM_WB      = 5'd6,
        S_MEM_WR      = 5'd7,
        S_MEM_WR_WAIT = 5'd8,
        S_EXEC_R      = 5'd9,
        S_R_WB        = 5'd10,
        S_EXEC_I      = 5'd11,
        S_I_WB        = 5'd12,
        S_BRANCH      = 5'd13,
        S_JUMP        = 5'd14,
        S_EXCEPT      = 5'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [1:0] PCF_ALU    = 2'b00;
    localparam logic [1:0] PCF_ALUOUT = 2'b01;
    localparam logic [1:0] PCF_JUMP   = 2'b10;
    localparam logic [1:0] PCF_EPC    = 2'b11;

    localparam logic [1:0] ULAB_REG   = 2'b00;
    localparam logic [1:0] ULAB_FOUR  = 2'b01;
    localparam logic [1:0] ULAB_IMM   = 2'b10;
    localparam logic [1:0] ULAB_SHIFT = 2'b11;

    function automatic logic is_wait(input state_t s);
        return (s == S_FETCH_WAIT) || (s == S_MEM_RD_WAIT) || (s == S_MEM_WR_WAIT);
    endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory wait counter: counts idle wait cycles and flags the cycle in which
// one more idle cycle would reach the limit.
module contador_espera #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W:0]   count_next;

    // expired is high during the idle cycle that completes the limit, so the
    // FSM leaves the wait state at the end of that cycle.
    assign count_next = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
    assign expired    = (count_next >= {1'b0, limit});

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_next[W-1:0];
        end
    end

endmodule

// File: rtl/controlador_multiciclo.sv
// Multicycle MIPS-style control unit with memory handshake, wait timeout and
// exception sequencing.
module controlador_multiciclo
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8,
    parameter int STATE_W     = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic               Overflow,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               CtrMem,
    output logic               IREsc,
    output logic               IouD,
    output logic               PCEsc,
    output logic               PCEscCond,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemParaReg,
    output logic               EPCEsc,
    output logic [1:0]         ULAOp,
    output logic [1:0]         ULAFonteB,
    output logic [1:0]         PCFonte,
    output logic               ULAFonteA,
    output logic               excecao,
    output logic [STATE_W-1:0] state
);

    // Handshake: mem_req stays high through the request and wait states; the
    // access completes in the cycle mem_ready is sampled high.
    state_t     state_q, state_d;
    logic       expired;
    logic [4:0] state_code;

    assign state_code = state_q;
    assign state      = STATE_W'(state_code);

    contador_espera #(.W(8)) u_espera (
        .clock   (clock),
        .clear   (reset || !is_wait(state_q)),
        .enable  (is_wait(state_q) && !mem_ready),
        .limit   (8'(MEM_TIMEOUT)),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = mem_ready ? S_DECODE : (expired ? S_EXCEPT : S_FETCH_WAIT);
            S_DECODE: begin
                case (OpCode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_EXCEPT;
                endcase
            end
            S_MEM_ADDR:    state_d = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:      state_d = mem_ready ? S_MEM_WB : S_MEM_RD_WAIT;
            S_MEM_RD_WAIT: state_d = mem_ready ? S_MEM_WB : (expired ? S_EXCEPT : S_MEM_RD_WAIT);
            S_MEM_WB:      state_d = S_FETCH;
            S_MEM_WR:      state_d = mem_ready ? S_FETCH : S_MEM_WR_WAIT;
            S_MEM_WR_WAIT: state_d = mem_ready ? S_FETCH : (expired ? S_EXCEPT : S_MEM_WR_WAIT);
            S_EXEC_R:      state_d = S_R_WB;
            S_R_WB:        state_d = Overflow ? S_EXCEPT : S_FETCH;
            S_EXEC_I:      state_d = S_I_WB;
            S_I_WB:        state_d = Overflow ? S_EXCEPT : S_FETCH;
            default:       state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        CtrMem     = 1'b0;
        IREsc      = 1'b0;
        IouD       = 1'b0;
        PCEsc      = 1'b0;
        PCEscCond  = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemParaReg = 1'b0;
        EPCEsc     = 1'b0;
        ULAOp      = 2'b00;
        ULAFonteB  = ULAB_REG;
        PCFonte    = PCF_ALU;
        ULAFonteA  = 1'b0;
        excecao    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ULAFonteB = ULAB_FOUR;
            end
            S_FETCH_WAIT: begin
                mem_req = 1'b1;
                IREsc   = mem_ready;
                PCEsc   = mem_ready;
            end
            S_DECODE: ULAFonteB = ULAB_SHIFT;
            S_MEM_ADDR, S_EXEC_I: begin
                ULAFonteA = 1'b1;
                ULAFonteB = ULAB_IMM;
            end
            S_MEM_RD, S_MEM_RD_WAIT: begin
                mem_req = 1'b1;
                IouD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemParaReg = 1'b1;
            end
            S_MEM_WR, S_MEM_WR_WAIT: begin
                mem_req = 1'b1;
                IouD    = 1'b1;
                CtrMem  = 1'b1;
            end
            S_EXEC_R: begin
                ULAFonteA = 1'b1;
                ULAOp     = 2'b10;
            end
            S_R_WB: begin
                RegWrite = !Overflow;
                RegDst   = 1'b1;
            end
            S_I_WB: RegWrite = !Overflow;
            S_BRANCH: begin
                ULAFonteA = 1'b1;
                ULAOp     = 2'b01;
                PCEscCond = 1'b1;
                PCFonte   = PCF_ALUOUT;
            end
            S_JUMP: begin
                PCEsc   = 1'b1;
                PCFonte = PCF_JUMP;
            end
            S_EXCEPT: begin
                EPCEsc  = 1'b1;
                excecao = 1'b1;
                PCEsc   = 1'b1;
                PCFonte = PCF_EPC;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controlador_multiciclo.sv
// Bench for controlador_multiciclo: an instruction-level model plans each
// cycle, the driver replays it and a negedge monitor checks every cycle.
module tb_controlador_multiciclo;
    import cpu_pkg::*;

    localparam int TMO = 4;
    localparam int W   = 23;

    typedef struct {
        state_t st;
        logic   rdy;
        logic   ovf;
    } cyc_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OpCode = '0;
    logic       Overflow = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, CtrMem, IREsc, IouD, PCEsc, PCEscCond, RegWrite, RegDst;
    logic       MemParaReg, EPCEsc, ULAFonteA, excecao;
    logic [1:0] ULAOp, ULAFonteB, PCFonte;
    logic [4:0] state;

    logic [W-1:0] exp_q[$];
    cyc_t         plan[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc_no = 0;

    always #5 clock = ~clock;

    controlador_multiciclo #(.MEM_TIMEOUT(TMO), .STATE_W(5)) dut (
        .clock(clock), .reset(reset), .OpCode(OpCode), .Overflow(Overflow),
        .mem_ready(mem_ready), .mem_req(mem_req), .CtrMem(CtrMem), .IREsc(IREsc),
        .IouD(IouD), .PCEsc(PCEsc), .PCEscCond(PCEscCond), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemParaReg(MemParaReg), .EPCEsc(EPCEsc), .ULAOp(ULAOp),
        .ULAFonteB(ULAFonteB), .PCFonte(PCFonte), .ULAFonteA(ULAFonteA),
        .excecao(excecao), .state(state)
    );

    logic [W-1:0] act_word;
    assign act_word = {state, mem_req, IouD, CtrMem, IREsc, PCEsc, PCEscCond, RegWrite,
                       RegDst, MemParaReg, EPCEsc, excecao, ULAFonteA, ULAOp, ULAFonteB, PCFonte};

    // Expected control word for one cycle, straight from the per-state table.
    function automatic logic [W-1:0] exp_word(input cyc_t c);
        logic req, iod, ctr, ir, pc, pcc, rw, rd, mpr, epc, exc, fa;
        logic [1:0] op, fb, pf;
        logic [4:0] sc;
        {req, iod, ctr, ir, pc, pcc, rw, rd, mpr, epc, exc, fa} = '0;
        op = 2'b00; fb = 2'b00; pf = 2'b00;
        sc = c.st;
        case (c.st)
            S_FETCH:       begin req = 1; fb = 2'b01; end
            S_FETCH_WAIT:  begin req = 1; ir = c.rdy; pc = c.rdy; end
            S_DECODE:      fb = 2'b11;
            S_MEM_ADDR:    begin fa = 1; fb = 2'b10; end
            S_MEM_RD, S_MEM_RD_WAIT: begin req = 1; iod = 1; end
            S_MEM_WB:      begin rw = 1; mpr = 1; end
            S_MEM_WR, S_MEM_WR_WAIT: begin req = 1; iod = 1; ctr = 1; end
            S_EXEC_R:      begin fa = 1; op = 2'b10; end
            S_R_WB:        begin rw = !c.ovf; rd = 1; end
            S_EXEC_I:      begin fa = 1; fb = 2'b10; end
            S_I_WB:        rw = !c.ovf;
            S_BRANCH:      begin fa = 1; op = 2'b01; pcc = 1; pf = 2'b01; end
            S_JUMP:        begin pc = 1; pf = 2'b10; end
            S_EXCEPT:      begin epc = 1; exc = 1; pc = 1; pf = 2'b11; end
            default: ;
        endcase
        return {sc, req, iod, ctr, ir, pc, pcc, rw, rd, mpr, epc, exc, fa, op, fb, pf};
    endfunction

    // d >= 1: completion arrives in the d-th wait cycle unless the timeout hits first.
    task automatic plan_wait(input state_t ws, input int d, output bit to);
        to = 1'b0;
        if (d <= TMO) begin
            for (int i = 0; i < d - 1; i++) plan.push_back('{st: ws, rdy: 1'b0, ovf: 1'b0});
            plan.push_back('{st: ws, rdy: 1'b1, ovf: 1'b0});
        end else begin
            for (int i = 0; i < TMO; i++) plan.push_back('{st: ws, rdy: 1'b0, ovf: 1'b0});
            to = 1'b1;
        end
    endtask

    task automatic plan_access(input state_t rs, input state_t ws, input int d, output bit to);
        to = 1'b0;
        if (d == 0) begin
            plan.push_back('{st: rs, rdy: 1'b1, ovf: 1'b0});
        end else begin
            plan.push_back('{st: rs, rdy: 1'b0, ovf: 1'b0});
            plan_wait(ws, d, to);
        end
    endtask

    task automatic build_instr(input logic [5:0] opc, input logic ovf, input int df, input int dm);
        bit to;
        plan.delete();
        plan.push_back('{st: S_FETCH, rdy: 1'b0, ovf: 1'b0});
        plan_wait(S_FETCH_WAIT, df, to);
        if (to) begin
            plan.push_back('{st: S_EXCEPT, rdy: 1'b0, ovf: 1'b0});
            return;
        end
        plan.push_back('{st: S_DECODE, rdy: 1'b0, ovf: 1'b0});
        case (opc)
            OP_R, OP_ADDI: begin
                plan.push_back('{st: (opc == OP_R) ? S_EXEC_R : S_EXEC_I, rdy: 1'b0, ovf: 1'b0});
                plan.push_back('{st: (opc == OP_R) ? S_R_WB : S_I_WB, rdy: 1'b0, ovf: ovf});
                if (ovf) plan.push_back('{st: S_EXCEPT, rdy: 1'b0, ovf: 1'b0});
            end
            OP_LW: begin
                plan.push_back('{st: S_MEM_ADDR, rdy: 1'b0, ovf: 1'b0});
                plan_access(S_MEM_RD, S_MEM_RD_WAIT, dm, to);
                plan.push_back('{st: to ? S_EXCEPT : S_MEM_WB, rdy: 1'b0, ovf: 1'b0});
            end
            OP_SW: begin
                plan.push_back('{st: S_MEM_ADDR, rdy: 1'b0, ovf: 1'b0});
                plan_access(S_MEM_WR, S_MEM_WR_WAIT, dm, to);
                if (to) plan.push_back('{st: S_EXCEPT, rdy: 1'b0, ovf: 1'b0});
            end
            OP_BEQ:  plan.push_back('{st: S_BRANCH, rdy: 1'b0, ovf: 1'b0});
            OP_J:    plan.push_back('{st: S_JUMP, rdy: 1'b0, ovf: 1'b0});
            default: plan.push_back('{st: S_EXCEPT, rdy: 1'b0, ovf: 1'b0});
        endcase
    endtask

    // Replays the plan; cut >= 0 asserts reset in that cycle and abandons the rest.
    task automatic run_plan(input logic [5:0] opc, input int cut);
        OpCode = opc;
        for (int i = 0; i < plan.size(); i++) begin
            cyc_t c;
            c = plan[i];
            mem_ready = c.rdy;
            Overflow  = (c.st == S_R_WB || c.st == S_I_WB) ? c.ovf : 1'($urandom_range(0, 1));
            reset     = (i == cut);
            exp_q.push_back(exp_word(c));
            @(posedge clock);
            #1;
            if (reset) begin
                reset = 1'b0;
                break;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic do_instr(input logic [5:0] opc, input logic ovf, input int df, input int dm, input int cut);
        build_instr(opc, ovf, df, dm);
        run_plan(opc, cut);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (act_word !== e) begin
                errors++;
                $display("FAIL cyc_word cycle %0d: actual=%h required=%h (state %0d vs %0d)",
                         cyc_no, act_word, e, act_word[W-1 -: 5], e[W-1 -: 5]);
            end
        end
        cyc_no++;
    end

    initial begin
        logic [5:0] opcs [7];
        opcs = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'h3F};
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        do_instr(OP_LW, 1'b0, 2, 2, -1);
        do_instr(OP_SW, 1'b0, 1, 0, -1);
        do_instr(OP_R, 1'b1, 1, 0, -1);
        do_instr(6'h3F, 1'b0, 1, 0, -1);
        do_instr(OP_J, 1'b0, TMO, 0, -1);
        do_instr(OP_BEQ, 1'b0, TMO + 1, 0, -1);
        do_instr(OP_ADDI, 1'b1, 3, 0, -1);
        do_instr(OP_SW, 1'b0, 1, TMO + 2, -1);
        do_instr(OP_LW, 1'b0, 1, 6, 5);
        do_instr(OP_LW, 1'b0, 1, 1, -1);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] opc;
            opc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 6)];
            do_instr(opc, 1'($urandom_range(0, 2) == 0), $urandom_range(1, 6), $urandom_range(0, 6), -1);
        end

        repeat (2) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controlador_multiciclo.md
CONTROLADOR_MULTICICLO -- requirements
Module: controlador_multiciclo

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8, meaning max cycles waiting on mem_ready before raising a bus-error exception (legal range 1..255).
REQ-002 SHALL have parameter STATE_W, default 5, meaning width of the state output.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port OpCode  in  6  IR[31:26] of the current instruction.
REQ-006 SHALL have port Overflow  in  1  ALU overflow flag, sampled in execute states.
REQ-007 SHALL have port mem_ready  in  1  memory completion strobe for the current access.
REQ-008 SHALL have port mem_req  out  1  memory access request, held until accepted.
REQ-009 SHALL have ports CtrMem, IREsc, IouD, PCEsc, PCEscCond, RegWrite, RegDst, MemParaReg, EPCEsc  out  1 each  datapath enables and selects.
REQ-010 SHALL have ports ULAOp, ULAFonteB, PCFonte  out  2 each  ALU op class, ALU B select, PC source select.
REQ-011 SHALL have port ULAFonteA  out  1  ALU A select: 0 = PC, 1 = A.
REQ-012 SHALL have port excecao  out  1  high for exactly one cycle when an exception is taken.
REQ-013 SHALL have port state  out  STATE_W  encoding of the current state.

Function
REQ-014 States: FETCH, FETCH_WAIT, DECODE, MEM_ADDR, MEM_RD, MEM_RD_WAIT, MEM_WB, MEM_WR, MEM_WR_WAIT, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, EXCEPT.
REQ-015 Outputs SHALL be Moore (a function of state only), except that mem_ready advances the wait states and Overflow gates the write-back transitions.
REQ-016 FETCH: mem_req=1, IouD=0, ULAFonteA=0, ULAFonteB=01, ULAOp=00 -> FETCH_WAIT.
REQ-017 FETCH_WAIT: mem_req=1; on mem_ready, IREsc=1 and PCEsc=1 in that same cycle -> DECODE; otherwise remain.
REQ-018 DECODE: ULAFonteA=0, ULAFonteB=11 (branch target precompute). Dispatch on OpCode: 0x00 -> EXEC_R; 0x23 or 0x2B -> MEM_ADDR; 0x08 -> EXEC_I; 0x04 -> BRANCH; 0x02 -> JUMP; any other -> EXCEPT.
REQ-019 MEM_ADDR: ULAFonteA=1, ULAFonteB=10, ULAOp=00 -> MEM_RD when OpCode=0x23, else MEM_WR.
REQ-020 MEM_RD/MEM_RD_WAIT: mem_req=1, IouD=1; on mem_ready -> MEM_WB. MEM_WB: RegWrite=1, RegDst=0, MemParaReg=1 -> FETCH.
REQ-021 MEM_WR/MEM_WR_WAIT: mem_req=1, IouD=1, CtrMem=1; on mem_ready -> FETCH.
REQ-022 EXEC_R: ULAFonteA=1, ULAFonteB=00, ULAOp=10 -> R_WB. R_WB: RegWrite=1, RegDst=1, MemParaReg=0 -> FETCH.
REQ-023 EXEC_I: ULAFonteA=1, ULAFonteB=10, ULAOp=00 -> I_WB. I_WB: RegWrite=1, RegDst=0 -> FETCH.
REQ-024 Overflow: in R_WB or I_WB, if Overflow=1, RegWrite SHALL be 0 and the next state SHALL be EXCEPT.
REQ-025 BRANCH: ULAFonteA=1, ULAFonteB=00, ULAOp=01, PCEscCond=1, PCFonte=01 -> FETCH.
REQ-026 JUMP: PCEsc=1, PCFonte=10 -> FETCH.
REQ-027 EXCEPT: EPCEsc=1, excecao=1, PCEsc=1, PCFonte=11 -> FETCH. Duration is exactly one cycle.
REQ-028 Timeout: a wait counter SHALL clear on entry to each *_WAIT state and increment each cycle with mem_ready=0. When the count reaches MEM_TIMEOUT, the FSM SHALL go to EXCEPT and drop mem_req. Simultaneous mem_ready and timeout: mem_ready wins.
REQ-029 Unlisted outputs SHALL be 0 in every state. CtrMem and RegWrite SHALL never both be 1.

Reset
REQ-030 reset=1 at any clock edge, including mid-wait, SHALL force state FETCH and clear the wait counter. All outputs SHALL then take their FETCH values; excecao=0.
REQ-031 A pending memory access SHALL be abandoned on reset. The mem_ready of the abandoned access, if it arrives after reset, SHALL be treated as the fetch completion.

Structure
REQ-032 The state enum, opcode constants (R, LW, SW, BEQ, J, ADDI), and PCFonte/ULAFonteB encodings SHALL reside in shared package cpu_pkg.
REQ-033 The wait/timeout counter SHALL be one sub-module, contador_espera (clear, enable, limit, expired).

Verification
REQ-034 reset, then lw (0x23) with mem_ready asserted 2 cycles after each request -> state sequence FETCH, FETCH_WAIT×2, DECODE, MEM_ADDR, MEM_RD, MEM_RD_WAIT×2, MEM_WB, FETCH; RegWrite=1 only in MEM_WB.
REQ-035 sw (0x2B) with immediate mem_ready -> CtrMem=1 only during MEM_WR; no RegWrite in any cycle.
REQ-036 add (0x00) with Overflow=1 in R_WB -> RegWrite=0, excecao pulses 1 cycle, PCFonte=11, then FETCH.
REQ-037 OpCode 0x3F -> DECODE, then EXCEPT, then FETCH; EPCEsc=1 for one cycle.
REQ-038 MEM_TIMEOUT=4 with mem_ready held 0 in FETCH_WAIT -> EXCEPT after 4 wait cycles; mem_ready arriving exactly in cycle 4 -> DECODE instead.
REQ-039 reset asserted during MEM_RD_WAIT -> FETCH on the next cycle; RegWrite never pulses.
